// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, valid/ready on both sides.
// Optional key cache enabled by defining AES_KEY_CACHE_EN.
module aes128_decrypt_iter #(
    parameter int ZEROIZE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, EXPAND, ARK, ROUND, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt;
    logic [7:0]   rcon_q;
    logic [127:0] ct_q, rk_q, st_q, out_q;
    logic [127:0] exp_key, inv_key, round_t, round_mix;
    logic         cache_hit;
    logic [127:0] cache_key10;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8), with 0 mapping to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, r;
        sq = a;
        r  = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_expansion(input logic [127:0] k, input logic [31:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w0 = w0 ^ sub_rot_word(w3) ^ rc;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undoes key_expansion: recover the older words first, then w0 from the restored w3
    function automatic logic [127:0] inv_key_expansion(input logic [127:0] k, input logic [31:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w3 = w3 ^ w2;
        w2 = w2 ^ w1;
        w1 = w1 ^ w0;
        w0 = w0 ^ sub_rot_word(w3) ^ rc;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_byte(input logic [127:0] s);
        logic [127:0] o;
        for (int unsigned i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;

    always_comb begin
        exp_key   = key_expansion(rk_q, {rcon_q, 24'h0});
        inv_key   = inv_key_expansion(rk_q, {rcon_q, 24'h0});
        round_t   = add_round_key(inv_sub_byte(inv_shift_rows(st_q)), inv_key);
        round_mix = inv_mix_columns(round_t);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = cache_hit ? ARK : EXPAND;
            EXPAND:  if (cnt == 4'd9) state_d = ARK;
            ARK:     state_d = ROUND;
            ROUND:   if (cnt == 4'd0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt     <= '0;
            rcon_q  <= '0;
            ct_q    <= '0;
            rk_q    <= '0;
            st_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: if (in_valid) begin
                    ct_q   <= in_data;
                    rk_q   <= cache_hit ? cache_key10 : in_key;
                    rcon_q <= 8'h01;
                    cnt    <= '0;
                end
                EXPAND: begin
                    rk_q   <= exp_key;
                    rcon_q <= xtime(rcon_q);
                    cnt    <= cnt + 4'd1;
                end
                ARK: begin
                    st_q   <= add_round_key(ct_q, rk_q);
                    rcon_q <= 8'h36;
                    cnt    <= 4'd9;
                end
                ROUND: begin
                    st_q   <= (cnt != 4'd0) ? round_mix : round_t;
                    rk_q   <= inv_key;
                    rcon_q <= (rcon_q == 8'h1b) ? 8'h80 : (rcon_q >> 1);
                    cnt    <= cnt - 4'd1;
                    if (cnt == 4'd0) out_q <= round_t;
                end
                DONE: if (out_ready && ZEROIZE != 0) begin
                    st_q <= '0;
                    rk_q <= '0;
                    ct_q <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef AES_KEY_CACHE_EN
    logic         cache_v;
    logic [127:0] key_c, k10_c;

    assign cache_hit   = cache_v && (in_key == key_c);
    assign cache_key10 = k10_c;

    // rk_q holds K10 during ARK and the final inverse step yields K0
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_v <= 1'b0;
            key_c   <= '0;
            k10_c   <= '0;
        end else begin
            if (state_q == ARK) k10_c <= rk_q;
            if (state_q == ROUND && cnt == 4'd0) begin
                key_c   <= inv_key;
                cache_v <= 1'b1;
            end
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign cache_key10 = '0;
`endif

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Self-checking bench: forward AES-128 reference model encrypts, the DUT must decrypt back.
module tb_aes128_decrypt_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sb [256];
    logic         cache_v_m   = 1'b0;
    logic [127:0] cache_key_m = '0;

`ifdef AES_KEY_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

    aes128_decrypt_iter #(.ZEROIZE(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] x);
        return gm2(x) ^ x;
    endfunction

    // S-box from the generator-3 walk over the multiplicative group
    task automatic init_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gm2(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm2(a0) ^ gm3(a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm2(a1) ^ gm3(a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm2(a2) ^ gm3(a3);
                    s[4*c+3] = gm3(a0) ^ a1 ^ a2 ^ gm2(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic int exp_latency(input logic [127:0] key);
        return (CACHE_ON && cache_v_m && key == cache_key_m) ? 12 : 22;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one job, scramble inputs after accept, check latency and result, then drain
    task automatic do_job(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt,
                          input string name, input int rdelay);
        int lat, waited, exp_lat;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin step(); waited++; end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready: got %b expected 1", name, in_ready); end
        exp_lat  = exp_latency(key);
        in_valid = 1'b1; in_data = ct; in_key = key;
        step();
        lat = 1;
        in_valid = 1'b0; in_data = rand128(); in_key = rand128();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b expected 1", name, busy); end
        while (out_valid !== 1'b1 && lat < 60) begin step(); lat++; end
        n_checks++;
        if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat); end
        n_checks++;
        if (out_data !== pt) begin n_fail++; $display("FAIL %s data: got %h expected %h", name, out_data, pt); end
        repeat (rdelay) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        cache_v_m = 1'b1; cache_key_m = key;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_checks++;
        if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset out_data: got %h expected 0", out_data); end
        rst = 1'b0;
        cache_v_m = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset release in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_vectors();
        do_job(KEY1, CT1, PT1, "vec1", 0);
        do_job(KEY2, CT2, PT2, "vec2", 1);
    endtask

    task automatic test_random();
        logic [127:0] key, pt;
        for (int i = 0; i < 6; i++) begin
            key = rand128();
            pt  = rand128();
            do_job(key, aes_encrypt(key, pt), pt, "random", int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] key, pt;
        int waited;
        key = rand128(); pt = rand128();
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin step(); waited++; end
        in_valid = 1'b1; in_data = aes_encrypt(key, pt); in_key = key;
        step();
        in_data = rand128(); in_key = rand128();
        waited = 0;
        while (out_valid !== 1'b1 && waited < 60) begin step(); waited++; end
        in_valid = 1'b0;
        cache_v_m = 1'b1; cache_key_m = key;
        for (int i = 0; i < 15; i++) begin
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp out_valid: got %b expected 1", out_valid); end
            n_checks++;
            if (out_data !== pt) begin n_fail++; $display("FAIL bp data: got %h expected %h", out_data, pt); end
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp in_ready: got %b expected 0", in_ready); end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp release in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp release out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_midjob();
        int waited;
        bit seen;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin step(); waited++; end
        in_valid = 1'b1; in_data = CT1; in_key = KEY1;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort in_ready during rst: got %b expected 0", in_ready); end
        rst = 1'b0;
        cache_v_m = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b expected 0", busy); end
        seen = 1'b0;
        repeat (30) begin
            step();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL abort out_valid rose: got %b expected 0", seen); end
        do_job(KEY1, CT1, PT1, "after_abort", 0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] ka, pa, kb, pb;
        int lat, waited, exp_a, exp_b;
        ka = rand128(); pa = rand128();
        kb = rand128(); pb = rand128();
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin step(); waited++; end
        exp_a = exp_latency(ka);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = aes_encrypt(ka, pa); in_key = ka;
        step();
        lat = 1;
        in_data = aes_encrypt(kb, pb); in_key = kb;
        while (out_valid !== 1'b1 && lat < 60) begin step(); lat++; end
        n_checks++;
        if (lat != exp_a) begin n_fail++; $display("FAIL b2b first latency: got %0d expected %0d", lat, exp_a); end
        n_checks++;
        if (out_data !== pa) begin n_fail++; $display("FAIL b2b first data: got %h expected %h", out_data, pa); end
        cache_v_m = 1'b1; cache_key_m = ka;
        exp_b = exp_latency(kb);
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b in_ready after handshake: got %b expected 1", in_ready); end
        step();
        lat = 1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b second accept busy: got %b expected 1", busy); end
        while (out_valid !== 1'b1 && lat < 60) begin step(); lat++; end
        in_valid = 1'b0;
        n_checks++;
        if (lat != exp_b) begin n_fail++; $display("FAIL b2b second latency: got %0d expected %0d", lat, exp_b); end
        n_checks++;
        if (out_data !== pb) begin n_fail++; $display("FAIL b2b second data: got %h expected %h", out_data, pb); end
        step();
        out_ready = 1'b0;
        cache_v_m = 1'b1; cache_key_m = kb;
    endtask

    task automatic test_cache();
        do_job(KEY1, CT1, PT1, "cache_fill", 0);
        do_job(KEY1, CT1, PT1, "cache_hit", 0);
        do_job(KEY2, CT2, PT2, "cache_miss", 0);
    endtask

    initial begin
        init_sbox();
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_midjob();
        test_back_to_back();
        if (CACHE_ON) test_cache();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
